// File: rtl/pulse_request_arbiter.sv
// rtl/pulse_request_arbiter.sv - round-robin arbiter granting one engine run per held request level
module pulse_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_level,
    input  logic               engine_done,
    output logic               start_pulse,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] ack,
    output logic               timeout_err,
    output logic               busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [NUM_REQ-1:0] armed_q;
    logic [ID_W-1:0]    grant_id_q;
    logic               start_pulse_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               timeout_err_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] eligible;
    logic               sel_valid_d;
    logic [ID_W-1:0]    sel_id_d;
    logic [NUM_REQ-1:0] armed_d;
    int                 idx;

    assign eligible = req_level & armed_q;

    // Search begins one past the previous owner so every requester gets a turn.
    always_comb begin
        sel_valid_d = 1'b0;
        sel_id_d    = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!sel_valid_d && eligible[idx[ID_W-1:0]]) begin
                sel_valid_d = 1'b1;
                sel_id_d    = idx[ID_W-1:0];
            end
        end
    end

    // A low level re-arms; the grant edge disarms so a held level is served once.
    always_comb begin
        armed_d = armed_q | ~req_level;
        if (state_q == S_IDLE && sel_valid_d) begin
            armed_d = armed_d & ~(NUM_REQ'(1) << sel_id_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            armed_q       <= '1;
            grant_id_q    <= '0;
            start_pulse_q <= 1'b0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            start_pulse_q <= 1'b0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_valid_d) begin
                        grant_id_q    <= sel_id_d;
                        state_q       <= S_START;
                        start_pulse_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    // Done wins over a timeout landing on the same cycle.
                    if (engine_done) begin
                        state_q <= S_ACK;
                        ack_q   <= NUM_REQ'(1) << grant_id_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= S_IDLE;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        last_grant_q  <= grant_id_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    last_grant_q <= grant_id_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_pulse = start_pulse_q;
    assign grant_id    = grant_id_q;
    assign ack         = ack_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_request_arbiter.sv
// tb/tb_pulse_request_arbiter.sv - directed self-checking bench for pulse_request_arbiter
module tb_pulse_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;

    logic               clk;
    logic               reset;
    logic [NUM_REQ-1:0] req_level;
    logic               engine_done;
    logic               start_pulse;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] ack;
    logic               timeout_err;
    logic               busy;

    int n_checks;
    int n_fail;

    pulse_request_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_level   (req_level),
        .engine_done (engine_done),
        .start_pulse (start_pulse),
        .grant_id    (grant_id),
        .ack         (ack),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start_pulse) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int starts;
        int exp_id;
        logic [NUM_REQ-1:0] exp_ack;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        req_level   = '0;
        engine_done = 1'b0;
        tick();
        tick();
        check("rst_start", 32'(start_pulse), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        reset = 1'b1;

        // Single request, done 5 cycles after start
        req_level = 4'b0001;
        tick();
        check("s1_start", 32'(start_pulse), 32'd1);
        check("s1_gid", 32'(grant_id), 32'd0);
        check("s1_busy", 32'(busy), 32'd1);
        tick();
        check("s1_wait_nostart", 32'(start_pulse), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("s1_noack_early", 32'(ack), 32'd0);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("s1_ack", 32'(ack), 32'b0001);
        check("s1_ack_tmo", 32'(timeout_err), 32'd0);
        tick();
        check("s1_ack_clear", 32'(ack), 32'd0);
        check("s1_idle_busy", 32'(busy), 32'd0);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            starts += int'(start_pulse);
        end
        check("s1_no_restart", 32'(starts), 32'd0);
        req_level = '0;
        tick();

        // Round-robin with all requesters held
        do_reset();
        req_level = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_id = r % NUM_REQ;
            tick();
            wait_start("rr_start_seen");
            check("rr_gid", 32'(grant_id), 32'(exp_id));
            tick();
            engine_done = 1'b1;
            tick();
            engine_done = 1'b0;
            exp_ack = '0;
            exp_ack[exp_id] = 1'b1;
            check("rr_ack", 32'(ack), 32'(exp_ack));
            req_level[exp_id] = 1'b0;
            tick();
            req_level[exp_id] = 1'b1;
        end
        req_level = '0;
        tick();
        tick();

        // Timeout on requester 2
        do_reset();
        req_level = 4'b0100;
        tick();
        check("to_gid", 32'(grant_id), 32'd2);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check("to_not_yet", 32'(timeout_err), 32'd0);
            check("to_no_ack", 32'(ack), 32'd0);
        end
        check("to_busy_wait", 32'(busy), 32'd1);
        tick();
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_ack_zero", 32'(ack), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        req_level = 4'b1111;
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        check("to_next_start", 32'(start_pulse), 32'd1);
        check("to_next_gid", 32'(grant_id), 32'd3);
        tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        req_level = '0;
        tick();
        tick();

        // Done in the same cycle as the timeout condition
        do_reset();
        req_level = 4'b0001;
        tick();
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("dt_still_wait", 32'(busy), 32'd1);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("dt_ack", 32'(ack), 32'b0001);
        check("dt_no_tmo", 32'(timeout_err), 32'd0);
        tick();
        check("dt_idle_tmo", 32'(timeout_err), 32'd0);
        req_level = '0;
        tick();

        // Spurious done in IDLE and START
        do_reset();
        engine_done = 1'b1;
        tick();
        check("sp_idle_busy", 32'(busy), 32'd0);
        check("sp_idle_ack", 32'(ack), 32'd0);
        check("sp_idle_start", 32'(start_pulse), 32'd0);
        engine_done = 1'b0;
        req_level = 4'b0001;
        tick();
        check("sp_start", 32'(start_pulse), 32'd1);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("sp_wait_ack", 32'(ack), 32'd0);
        check("sp_wait_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("sp_still_wait_ack", 32'(ack), 32'd0);
        check("sp_still_busy", 32'(busy), 32'd1);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("sp_real_ack", 32'(ack), 32'b0001);
        tick();
        req_level = '0;
        tick();

        // Reset mid-WAIT; last grant was 0 so 0011 first goes to 1
        req_level = 4'b0011;
        tick();
        check("rw_gid_before", 32'(grant_id), 32'd1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_ack", 32'(ack), 32'd0);
        check("rw_tmo", 32'(timeout_err), 32'd0);
        check("rw_start", 32'(start_pulse), 32'd0);
        check("rw_gid", 32'(grant_id), 32'd0);
        reset = 1'b1;
        tick();
        check("rw_regrant_start", 32'(start_pulse), 32'd1);
        check("rw_regrant_gid", 32'(grant_id), 32'd0);
        tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("rw_regrant_ack", 32'(ack), 32'b0001);
        req_level = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
